// File: rtl/aes128_enc_iter.sv
// ---------------------------------------------------------------------------
// aes128_enc_iter -- iterative AES-128 encryption engine
//
// Purpose:
//   Takes one 128-bit plaintext block and a 128-bit key. On accept it applies
//   the initial AddRoundKey. It then runs 10 rounds, one round per clock,
//   and expands the round keys on the fly. The ciphertext is held until
//   the consumer takes it.
//
//   State byte layout: s0 = [127:120], column-major (s0..s3 = column 0).
//   The key and the ciphertext use the same layout.
//
// Ports:
//   clk         in   1    sole clock, rising edge
//   rst         in   1    synchronous, active-high reset
//   in_valid    in   1    plaintext/key valid
//   in_ready    out  1    engine idle, can accept a block
//   plaintext   in   128  input block
//   key         in   128  cipher key
//   out_valid   out  1    ciphertext valid
//   out_ready   in   1    consumer accepts the ciphertext
//   ciphertext  out  128  result
//
// Optional build macro AES_ENC_STATUS_EN adds two status outputs:
//   busy        out  1    high in ROUND or DONE
//   round_dbg   out  4    current round counter
// ---------------------------------------------------------------------------

// Combinational forward S-box, implemented as a 256-entry ROM.
// i_data = 0 selects the most significant byte of the table.
module aes_sbox (
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);
   localparam logic [2047:0] C_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // (255 - i) * 8 == {~i, 3'b000}
   assign o_data = C_SBOX[{~i_data, 3'b000} +: 8];
endmodule

module aes128_enc_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext
`ifdef AES_ENC_STATUS_EN
   ,
   output logic         busy,
   output logic [3:0]   round_dbg
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t       r_fsm;
   state_t       w_fsm_nxt;
   logic [127:0] r_blk;
   logic [127:0] r_rk;
   logic [3:0]   r_round;
   logic [7:0]   r_rcon;

   logic         w_accept;
   logic         w_last;
   logic         w_in_ready;
   logic         w_out_valid;

   // ------------------------------------------------------------------------
   // GF(2^8) helpers
   // ------------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

   // ------------------------------------------------------------------------
   // Key expansion: next round key derived from the current one and rcon
   // ------------------------------------------------------------------------
   logic [31:0]  w_w0, w_w1, w_w2, w_w3;
   logic [31:0]  w_rot;
   logic [31:0]  w_sub;
   logic [31:0]  w_k0, w_k1, w_k2, w_k3;
   logic [127:0] w_rk_nxt;

   assign w_w0  = r_rk[127:96];
   assign w_w1  = r_rk[95:64];
   assign w_w2  = r_rk[63:32];
   assign w_w3  = r_rk[31:0];
   assign w_rot = {w_w3[23:0], w_w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_ksbox
      aes_sbox u_ksbox (
         .i_data (w_rot[8*g +: 8]),
         .o_data (w_sub[8*g +: 8])
      );
   end

   assign w_k0     = w_w0 ^ w_sub ^ {r_rcon, 24'h000000};
   assign w_k1     = w_w1 ^ w_k0;
   assign w_k2     = w_w2 ^ w_k1;
   assign w_k3     = w_w3 ^ w_k2;
   assign w_rk_nxt = {w_k0, w_k1, w_k2, w_k3};

   // ------------------------------------------------------------------------
   // Round function: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey
   // ------------------------------------------------------------------------
   logic [127:0] w_sb;
   logic [127:0] w_sr;
   logic [127:0] w_mc;
   logic [127:0] w_blk_nxt;

   for (genvar g = 0; g < 16; g++) begin : g_ssbox
      aes_sbox u_ssbox (
         .i_data (r_blk[127-8*g -: 8]),
         .o_data (w_sb[127-8*g -: 8])
      );
   end

   // Row r of column c takes the byte from column (c + r) mod 4.
   for (genvar c = 0; c < 4; c++) begin : g_sr_col
      for (genvar r = 0; r < 4; r++) begin : g_sr_row
         assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_mc
      assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
   end

   assign w_last    = (r_round == 4'd10);
   // The final round has no MixColumns step.
   assign w_blk_nxt = (w_last ? w_sr : w_mc) ^ w_rk_nxt;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // The ready/valid outputs decode only the registered state.
   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_accept    = 1'b0;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_accept  = 1'b1;
               w_fsm_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            if (w_last) begin
               w_fsm_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) begin
               w_fsm_nxt = S_IDLE;
            end
         end
         default: begin
            w_fsm_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   // r_rk is not reset: it is always reloaded before it is used.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blk   <= '0;
         r_round <= 4'd0;
         r_rcon  <= 8'h01;
      end else if (w_accept) begin
         r_blk   <= plaintext ^ key;
         r_rk    <= key;
         r_round <= 4'd1;
         r_rcon  <= 8'h01;
      end else if (r_fsm == S_ROUND) begin
         r_blk  <= w_blk_nxt;
         r_rk   <= w_rk_nxt;
         r_rcon <= xtime(r_rcon);
         if (!w_last) begin
            r_round <= r_round + 4'd1;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = w_out_valid;
   assign ciphertext = r_blk;

`ifdef AES_ENC_STATUS_EN
   assign busy      = (r_fsm == S_ROUND) || (r_fsm == S_DONE);
   assign round_dbg = r_round;
`else
   // The status outputs are not built; the datapath is unchanged.
`endif

endmodule

// File: tb/tb_aes128_enc_iter.sv
// ---------------------------------------------------------------------------
// tb_aes128_enc_iter -- directed, self-checking bench for aes128_enc_iter
//
// Uses the FIPS-197 App. B and App. C.1 vectors. Expected ciphertexts are
// queued at accept and compared when out_valid is seen.
// ---------------------------------------------------------------------------
module tb_aes128_enc_iter;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
`ifdef AES_ENC_STATUS_EN
   logic         busy;
   logic [3:0]   round_dbg;
`endif

   int           total = 0;
   int           bad   = 0;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   aes128_enc_iter dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext)
`ifdef AES_ENC_STATUS_EN
      ,
      .busy       (busy),
      .round_dbg  (round_dbg)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive a block, accept it on the next edge, then scramble the inputs.
   task automatic start_block(input logic [127:0] pt, input logic [127:0] k,
                              input logic [127:0] exp, input logic hold);
      plaintext = pt;
      key       = k;
      in_valid  = 1'b1;
      chk("in_ready_before_accept", 128'(in_ready), 128'(1'b1));
      tick;
      exp_q.push_back(exp);
      plaintext = rnd128();
      key       = rnd128();
      in_valid  = hold;
   endtask

   // Called one cycle after the accept edge. Counts the cycles until
   // out_valid, then checks the latency and the ciphertext.
   task automatic wait_result(input string tag);
      int           cycles;
      logic [127:0] e;
      cycles = 0;
`ifdef AES_ENC_STATUS_EN
      chk({tag, "_busy"}, 128'(busy), 128'(1'b1));
      chk({tag, "_round_dbg"}, 128'(round_dbg), 128'(4'd1));
`endif
      while (out_valid !== 1'b1 && cycles < 40) begin
         tick;
         cycles++;
`ifdef AES_ENC_STATUS_EN
         if (out_valid !== 1'b1) begin
            chk({tag, "_round_dbg"}, 128'(round_dbg), 128'(cycles + 1));
         end
         chk({tag, "_busy"}, 128'(busy), 128'(1'b1));
`endif
      end
      chk({tag, "_latency"}, 128'(cycles), 128'(10));
      chk({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'(1'b1));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk({tag, "_ct"}, ciphertext, e);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      plaintext = '0;
      key       = '0;
      repeat (3) tick;
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_ct", ciphertext, 128'h0);
`ifdef AES_ENC_STATUS_EN
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_round_dbg", 128'(round_dbg), 128'(4'd0));
`endif
      rst = 1'b0;
      tick;

      // App. B with out_ready held high
      out_ready = 1'b1;
      start_block(PT_B, KEY_B, CT_B, 1'b0);
      wait_result("appB");
      tick;
      chk("appB_idle_in_ready", 128'(in_ready), 128'(1'b1));
      chk("appB_idle_out_valid", 128'(out_valid), 128'(1'b0));

      // App. C.1 followed by 20 cycles of backpressure
      out_ready = 1'b0;
      start_block(PT_C, KEY_C, CT_C, 1'b0);
      wait_result("appC");
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         plaintext = rnd128();
         key       = rnd128();
         tick;
         chk("bp_ct_stable", ciphertext, CT_C);
         chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
         chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("bp_release_in_ready", 128'(in_ready), 128'(1'b1));
      chk("bp_release_out_valid", 128'(out_valid), 128'(1'b0));
      tick;
      chk("bp_no_capture", 128'(in_ready), 128'(1'b1));

      // Back-to-back: App. B then App. C.1 with in_valid held high
      start_block(PT_B, KEY_B, CT_B, 1'b1);
      plaintext = PT_C;
      key       = KEY_C;
      wait_result("b2b_first");
      tick;
      chk("b2b_handshake_in_ready", 128'(in_ready), 128'(1'b1));
      chk("b2b_handshake_out_valid", 128'(out_valid), 128'(1'b0));
      tick;
      chk("b2b_second_accept", 128'(in_ready), 128'(1'b0));
      exp_q.push_back(CT_C);
      in_valid  = 1'b0;
      plaintext = rnd128();
      key       = rnd128();
      wait_result("b2b_second");
      tick;

      // Reset asserted while round 5 is the current round
      start_block(PT_B, KEY_B, CT_B, 1'b0);
      repeat (4) tick;
`ifdef AES_ENC_STATUS_EN
      chk("midrst_round_dbg_pre", 128'(round_dbg), 128'(4'd5));
`endif
      rst = 1'b1;
      tick;
      chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("midrst_ct", ciphertext, 128'h0);
      exp_q.delete();
      rst = 1'b0;
      start_block(PT_B, KEY_B, CT_B, 1'b0);
      wait_result("midrst_appB");
      tick;
      chk("midrst_final_idle", 128'(in_ready), 128'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
